mem_access_ctrl: RTL and testbench

Initiator side of the single-port instruction/data block RAM. It accepts one CPU or IO-polling load/store request at a time over a valid/ready handshake and converts it into the RAM's native cycle protocol: word address, write-enable, and registered read data. Sub-word stores become read-modify-write sequences, because the RAM is word-write only. It sits between the CPU memory stage and the 8K x 32 RAM.

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/mem_byte_merge.sv | 21 ++
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the block-RAM access controller.
// The byte-merge helper reuses these constants.
package mem_ctrl_pkg;

  localparam int MEM_AW_DEF = 13;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] BE_FULL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational byte-lane merge: each enabled lane takes the new word's byte,
// and every other lane keeps the old word's byte.
module mem_byte_merge
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the single-port 8K x 32 instruction/data RAM. It turns one
// load/store request at a time into RAM cycles, using read-modify-write for sub-word stores.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  state_t              state;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W/8-1:0] lat_be;
  logic [DATA_W-1:0]   din_q;
  logic                rsp_load;
  logic [DATA_W-1:0]   merged;
  logic                addr_err;
  logic                unused_addr_lsbs;

  assign addr_err         = |req_addr[31:MEM_AW+2];
  assign unused_addr_lsbs = ^req_addr[1:0];

  assign req_ready = (state == IDLE) && rst_n;
  assign mem_we    = ((state == WR) || (state == MERGE)) && rst_n;

  // The RAM read word only appears during MERGE, so the merged write data is
  // muxed after the din register rather than being registered itself.
  assign mem_din   = (state == MERGE) ? merged : din_q;
  assign rsp_rdata = rsp_load ? mem_dout : '0;

  mem_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_word (mem_dout),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
      din_q     <= '0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (addr_err) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && (req_be == '0)) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end else begin
              mem_addr <= req_addr[MEM_AW+1:2];
              if (req_we && (req_be == BE_FULL)) begin
                state <= WR;
                din_q <= req_wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (lat_we) begin
            state <= MERGE;
          end else begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_load  <= 1'b1;
          end
        end
        MERGE, WR: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl against a behavioural 8K x 32 RAM
// with registered read data.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram [0:8191];
  int          we_cnt;
  logic [12:0] last_we_addr;
  logic [31:0] last_we_din;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    bit          err;
    logic [31:0] rdata;
    int          we_cycles;
    logic [12:0] we_addr;
    logic [31:0] we_din;
  } vec_t;

  vec_t vecs [13];

  mem_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    else        mem_dout      <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt       = we_cnt + 1;
      last_we_addr = mem_addr;
      last_we_din  = mem_din;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
    we_cnt = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check_output({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check_output({tag, "_err"}, 32'(rsp_err), 32'(v.err));
    check_output({tag, "_rdata"}, rsp_rdata, v.rdata);
    @(negedge clk);
    check_output({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
    check_output({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check_output({tag, "_we_cycles"}, 32'(we_cnt), 32'(v.we_cycles));
    if (v.we_cycles != 0) begin
      check_output({tag, "_we_addr"}, 32'(last_we_addr), 32'(v.we_addr));
      check_output({tag, "_we_din"}, last_we_din, v.we_din);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_output("rst_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_ready", 32'(req_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_din", mem_din, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   rsp_seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    mem_dout  = '0;
    we_cnt    = 0;
    last_we_addr = '0;
    last_we_din  = '0;
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    ram[5] = 32'h11223344;
    ram[0] = 32'hA5A5A5A5;

    //           we    addr           wdata          be     lat err   rdata          wes addr     din
    vecs[0]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,  2, 1'b0, 32'h11223344, 0, 13'h0,    32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0014, 32'hAABBCCDD,  4'h2,  3, 1'b0, 32'h0,        1, 13'h5,    32'h1122CC44};
    vecs[2]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,  2, 1'b0, 32'h1122CC44, 0, 13'h0,    32'h0};
    vecs[3]  = '{1'b1, 32'h0000_7FFC, 32'hDEADBEEF,  4'hF,  2, 1'b0, 32'h0,        1, 13'h1FFF, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h0000_7FFC, 32'h0,         4'h0,  2, 1'b0, 32'hDEADBEEF, 0, 13'h0,    32'h0};
    vecs[5]  = '{1'b0, 32'h0000_8000, 32'h0,         4'h0,  1, 1'b1, 32'h0,        0, 13'h0,    32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,  2, 1'b0, 32'h1122CC44, 0, 13'h0,    32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0014, 32'hFFFFFFFF,  4'h0,  1, 1'b0, 32'h0,        0, 13'h0,    32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,  2, 1'b0, 32'h1122CC44, 0, 13'h0,    32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0016, 32'h55000066,  4'h9,  3, 1'b0, 32'h0,        1, 13'h5,    32'h5522CC66};
    vecs[10] = '{1'b0, 32'h0000_0017, 32'h0,         4'h0,  2, 1'b0, 32'h5522CC66, 0, 13'h0,    32'h0};
    vecs[11] = '{1'b1, 32'h8000_0014, 32'h12345678,  4'hF,  1, 1'b1, 32'h0,        0, 13'h0,    32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,  2, 1'b0, 32'hA5A5A5A5, 0, 13'h0,    32'h0};

    do_reset();
    for (int i = 0; i < 13; i++) apply_stimulus(vecs[i], $sformatf("v%0d", i));

    // Held req_valid: a load followed by a be=0 store without dropping valid.
    @(negedge clk);
    we_cnt    = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h14;
    req_be    = 4'h0;
    check_output("hold_ready0", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check_output("hold_rd_ready", 32'(req_ready), 32'd0);
    check_output("hold_rd_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_output("hold_done_valid", 32'(rsp_valid), 32'd1);
    check_output("hold_done_rdata", rsp_rdata, 32'h5522CC66);
    check_output("hold_done_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_output("hold_idle_ready", 32'(req_ready), 32'd1);
    check_output("hold_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_output("hold_be0_valid", 32'(rsp_valid), 32'd1);
    check_output("hold_be0_err", 32'(rsp_err), 32'd0);
    check_output("hold_be0_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_output("hold_end_ready", 32'(req_ready), 32'd1);
    check_output("hold_end_valid", 32'(rsp_valid), 32'd0);
    check_output("hold_we_cycles", 32'(we_cnt), 32'd0);
    check_output("hold_ram5", ram[5], 32'h5522CC66);

    // Reset sampled during MERGE must suppress the write and drop the response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h14;
    req_wdata = 32'h00EE0000;
    req_be    = 4'h4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_seen  = 0;
    @(negedge clk);
    if (rsp_valid === 1'b1) rsp_seen++;
    @(negedge clk);
    check_output("mrst_merge_we", 32'(mem_we), 32'd1);
    check_output("mrst_merge_din", mem_din, 32'h55EECC66);
    rst_n = 1'b0;
    #1;
    check_output("mrst_we_suppressed", 32'(mem_we), 32'd0);
    @(negedge clk);
    if (rsp_valid === 1'b1) rsp_seen++;
    rst_n = 1'b1;
    #1;
    check_output("mrst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    check_output("mrst_no_rsp", 32'(rsp_seen), 32'd0);
    check_output("mrst_ram5", ram[5], 32'h5522CC66);
    v = '{1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b0, 32'h5522CC66, 0, 13'h0, 32'h0};
    apply_stimulus(v, "mrst_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
